// File: rtl/pattern_pkg.sv
// Shared types for the bit-serial pattern source and its detector counterpart.
package pattern_pkg;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAPWAIT} ser_state_t;

  localparam logic [3:0] PATTERN_1011 = 4'b1011;

endpackage

// File: rtl/pattern_serializer.sv
// Bit-serial transmitter: takes a parallel word on a valid/ready port and shifts it
// out one registered bit per clock, with optional idle gap cycles between words.
module pattern_serializer
  import pattern_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int GAP       = 0,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_word,
  output logic             out_bit,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy
);

  localparam int BC_W  = $clog2(WIDTH);
  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  ser_state_t       state, state_nxt;
  logic [BC_W-1:0]  bit_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [WIDTH-1:0] sreg;
  logic             last_bit;
  logic             accept;

  // Bit that leaves the word first, and the word with that bit consumed.
  function automatic logic head(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign last_bit   = (state == S_SHIFT) && (bit_cnt == LAST_BIT);
  // With no gap the next word may be accepted while the last bit is on the wire.
  assign load_ready = (state == S_IDLE) || ((GAP == 0) && last_bit);
  assign accept     = load_valid && load_ready;
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (accept) state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (last_bit) begin
          if (GAP > 0)     state_nxt = S_GAPWAIT;
          else if (accept) state_nxt = S_SHIFT;
          else             state_nxt = S_IDLE;
        end
      end
      S_GAPWAIT: if (gap_cnt == LAST_GAP) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output stage: out_bit/out_valid/out_last are registered, cleared whenever no bit is sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg      <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      if (accept) begin
        sreg      <= advance(load_word);
        out_bit   <= head(load_word);
        out_valid <= 1'b1;
        bit_cnt   <= '0;
      end else if ((state == S_SHIFT) && !last_bit) begin
        sreg      <= advance(sreg);
        out_bit   <= head(sreg);
        out_valid <= 1'b1;
        out_last  <= (bit_cnt == LAST_BIT - 1'b1);
        bit_cnt   <= bit_cnt + 1'b1;
      end else if (last_bit) begin
        bit_cnt <= '0;
      end

      if (last_bit && (GAP > 0)) gap_cnt <= '0;
      else if (state == S_GAPWAIT) gap_cnt <= gap_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pattern_serializer.sv
// Directed and randomized checks of pattern_serializer in three parameterizations.
module tb_pattern_serializer;
  import pattern_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  // a: GAP=0 MSB first; b: GAP=2 MSB first; c: GAP=0 LSB first
  logic       lv_a = 1'b0, lr_a, ob_a, ov_a, ol_a, bz_a;
  logic [3:0] lw_a = '0;
  logic       lv_b = 1'b0, lr_b, ob_b, ov_b, ol_b, bz_b;
  logic [3:0] lw_b = '0;
  logic       lv_c = 1'b0, lr_c, ob_c, ov_c, ol_c, bz_c;
  logic [3:0] lw_c = '0;

  pattern_serializer #(.WIDTH(4), .GAP(0), .MSB_FIRST(1)) dut_a (
    .clk(clk), .rst(rst), .load_valid(lv_a), .load_ready(lr_a), .load_word(lw_a),
    .out_bit(ob_a), .out_valid(ov_a), .out_last(ol_a), .busy(bz_a));

  pattern_serializer #(.WIDTH(4), .GAP(2), .MSB_FIRST(1)) dut_b (
    .clk(clk), .rst(rst), .load_valid(lv_b), .load_ready(lr_b), .load_word(lw_b),
    .out_bit(ob_b), .out_valid(ov_b), .out_last(ol_b), .busy(bz_b));

  pattern_serializer #(.WIDTH(4), .GAP(0), .MSB_FIRST(0)) dut_c (
    .clk(clk), .rst(rst), .load_valid(lv_c), .load_ready(lr_c), .load_word(lw_c),
    .out_bit(ob_c), .out_valid(ov_c), .out_last(ol_c), .busy(bz_c));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    lv_a = 1'b1; lw_a = 4'hF;
    lv_b = 1'b1; lw_b = 4'hF;
    lv_c = 1'b1; lw_c = 4'hF;
    step();
    step();
    nchk++;
    if ({ov_a, ob_a, ol_a, bz_a} !== 4'b0000) begin
      nerr++; $display("FAIL reset_outputs_a: got %b exp 0000", {ov_a, ob_a, ol_a, bz_a});
    end
    nchk++;
    if ({bz_b, ov_b, bz_c, ov_c} !== 4'b0000) begin
      nerr++; $display("FAIL reset_outputs_bc: got %b exp 0000", {bz_b, ov_b, bz_c, ov_c});
    end
    rst = 1'b0;
    lv_a = 1'b0; lv_b = 1'b0; lv_c = 1'b0;
    #1;
    nchk++;
    if ({lr_a, lr_b, lr_c} !== 3'b111) begin
      nerr++; $display("FAIL reset_ready: got %b exp 111", {lr_a, lr_b, lr_c});
    end
    step();
    nchk++;
    if ({ov_a, bz_a, ov_b, bz_b} !== 4'b0000) begin
      nerr++; $display("FAIL reset_no_accept: got %b exp 0000", {ov_a, bz_a, ov_b, bz_b});
    end
  endtask

  task automatic test_single_word();
    logic [3:0] pat;
    logic [4:0] expv;
    pat = PATTERN_1011;
    lv_a = 1'b1; lw_a = pat;
    step();
    lv_a = 1'b0; lw_a = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      expv = {1'b1, pat[3-i], (i == 3), (i == 3), 1'b1};
      nchk++;
      if ({ov_a, ob_a, ol_a, lr_a, bz_a} !== expv) begin
        nerr++; $display("FAIL single_bit%0d {valid,bit,last,ready,busy}: got %b exp %b",
                         i, {ov_a, ob_a, ol_a, lr_a, bz_a}, expv);
      end
      step();
    end
    nchk++;
    if ({ov_a, ob_a, ol_a, lr_a, bz_a} !== 5'b00010) begin
      nerr++; $display("FAIL single_idle_after: got %b exp 00010", {ov_a, ob_a, ol_a, lr_a, bz_a});
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  words [3];
    logic [11:0] stream;
    logic [3:0]  det_sr;
    logic        acc;
    int idx, ndet, nseen;
    words[0] = 4'b1011; words[1] = 4'b0110; words[2] = 4'b1011;
    stream = 12'b1011_0110_1011;
    det_sr = '0; idx = 0; ndet = 0; nseen = 0;
    lv_a = 1'b1; lw_a = words[0];
    for (int cyc = 0; cyc < 12; cyc++) begin
      acc = lv_a && lr_a;
      step();
      if (acc) begin
        idx++;
        if (idx < 3) lw_a = words[idx];
        else lv_a = 1'b0;
      end
      nchk++;
      if ({ov_a, ob_a} !== {1'b1, stream[11-cyc]}) begin
        nerr++; $display("FAIL b2b_cycle%0d {valid,bit}: got %b exp %b", cyc, {ov_a, ob_a}, {1'b1, stream[11-cyc]});
      end
      if (ov_a) begin
        det_sr = {det_sr[2:0], ob_a};
        nseen++;
        if (nseen >= 4 && det_sr == PATTERN_1011) ndet++;
      end
    end
    lv_a = 1'b0;
    nchk++;
    if (idx !== 3) begin
      nerr++; $display("FAIL b2b_accepts: got %0d exp 3", idx);
    end
    nchk++;
    if (ndet !== 3) begin
      nerr++; $display("FAIL b2b_detections: got %0d exp 3", ndet);
    end
    step();
    nchk++;
    if ({ov_a, bz_a} !== 2'b00) begin
      nerr++; $display("FAIL b2b_idle_after: got %b exp 00", {ov_a, bz_a});
    end
  endtask

  task automatic test_gap();
    logic [3:0] pat;
    logic [3:0] expv;
    logic       acc;
    int nacc, ph;
    pat = PATTERN_1011;
    nacc = 0;
    lv_b = 1'b1; lw_b = pat;
    for (int cyc = 0; cyc < 14; cyc++) begin
      acc = lv_b && lr_b;
      step();
      if (acc) nacc++;
      ph = cyc % 7;
      expv = {(ph < 4), (ph < 4) ? pat[3-ph] : 1'b0, (ph == 6), (ph < 6)};
      nchk++;
      if ({ov_b, ob_b, lr_b, bz_b} !== expv) begin
        nerr++; $display("FAIL gap_cycle%0d {valid,bit,ready,busy}: got %b exp %b", cyc, {ov_b, ob_b, lr_b, bz_b}, expv);
      end
    end
    lv_b = 1'b0;
    nchk++;
    if (nacc !== 2) begin
      nerr++; $display("FAIL gap_accepts: got %0d exp 2", nacc);
    end
  endtask

  task automatic test_lsb_first();
    logic [3:0] pat;
    logic [2:0] expv;
    pat = PATTERN_1011;
    lv_c = 1'b1; lw_c = pat;
    step();
    lv_c = 1'b0; lw_c = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      expv = {1'b1, pat[i], (i == 3)};
      nchk++;
      if ({ov_c, ob_c, ol_c} !== expv) begin
        nerr++; $display("FAIL lsb_bit%0d {valid,bit,last}: got %b exp %b", i, {ov_c, ob_c, ol_c}, expv);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_word();
    logic [3:0] pat;
    lv_a = 1'b1; lw_a = 4'b0110;
    step();
    lv_a = 1'b0;
    step();
    step();
    nchk++;
    if ({ov_a, ob_a, bz_a} !== 3'b111) begin
      nerr++; $display("FAIL midrst_before {valid,bit,busy}: got %b exp 111", {ov_a, ob_a, bz_a});
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    nchk++;
    if ({ov_a, ob_a, ol_a, bz_a} !== 4'b0000) begin
      nerr++; $display("FAIL midrst_abort: got %b exp 0000", {ov_a, ob_a, ol_a, bz_a});
    end
    step();
    nchk++;
    if ({ov_a, bz_a, lr_a} !== 3'b001) begin
      nerr++; $display("FAIL midrst_no_resume {valid,busy,ready}: got %b exp 001", {ov_a, bz_a, lr_a});
    end
    pat = PATTERN_1011;
    lv_a = 1'b1; lw_a = pat;
    step();
    lv_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nchk++;
      if ({ov_a, ob_a, ol_a} !== {1'b1, pat[3-i], (i == 3)}) begin
        nerr++; $display("FAIL midrst_reload_bit%0d: got %b exp %b", i, {ov_a, ob_a, ol_a}, {1'b1, pat[3-i], (i == 3)});
      end
      step();
    end
  endtask

  task automatic test_random();
    logic [3:0] q[$];
    logic [3:0] cur, w;
    logic       acc;
    int sent, got, nb, cyc;
    sent = 0; got = 0; nb = 0; cyc = 0; cur = '0;
    while (got < 200 && cyc < 6000) begin
      lv_a = (sent < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
      lw_a = 4'($urandom);
      acc = lv_a && lr_a;
      if (acc) begin
        q.push_back(lw_a);
        sent++;
      end
      step();
      cyc++;
      if (ov_a) begin
        cur = {cur[2:0], ob_a};
        nb++;
        if (ol_a) begin
          nchk++;
          if (q.size() == 0) begin
            nerr++; $display("FAIL rand_word%0d: got %h with no word pending", got, cur);
          end else begin
            w = q.pop_front();
            if (cur !== w || nb != 4) begin
              nerr++; $display("FAIL rand_word%0d: got %h (%0d bits) exp %h (4 bits)", got, cur, nb, w);
            end
          end
          got++;
          nb = 0;
        end
      end else begin
        nchk++;
        if ({ob_a, ol_a} !== 2'b00) begin
          nerr++; $display("FAIL rand_idle_outputs cycle%0d: got %b exp 00", cyc, {ob_a, ol_a});
        end
      end
    end
    lv_a = 1'b0;
    nchk++;
    if (got != 200 || q.size() != 0) begin
      nerr++; $display("FAIL rand_count: got %0d words, %0d pending, exp 200 and 0", got, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_gap();
    test_lsb_first();
    test_reset_mid_word();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
